// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multicycle ARM controller:
// FSM states, ALU op codes, condition codes, mux selects, DP decode.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_ORR = 4'b0011,
        ALU_EOR = 4'b0100,
        ALU_RSB = 4'b0101,
        ALU_MOV = 4'b0110,
        ALU_BIC = 4'b0111,
        ALU_MVN = 4'b1000
    } alu_op_t;

    typedef enum logic [3:0] {
        C_EQ = 4'b0000, C_NE = 4'b0001,
        C_CS = 4'b0010, C_CC = 4'b0011,
        C_MI = 4'b0100, C_PL = 4'b0101,
        C_VS = 4'b0110, C_VC = 4'b0111,
        C_HI = 4'b1000, C_LS = 4'b1001,
        C_GE = 4'b1010, C_LT = 4'b1011,
        C_GT = 4'b1100, C_LE = 4'b1101,
        C_AL = 4'b1110, C_NV = 4'b1111
    } cond_t;

    localparam logic [1:0] RS_ALUOUT = 2'b00;
    localparam logic [1:0] RS_DATA   = 2'b01;
    localparam logic [1:0] RS_ALURES = 2'b10;

    localparam logic [1:0] SA_RD1 = 2'b00;
    localparam logic [1:0] SA_PC  = 2'b01;

    localparam logic [1:0] SB_RD2  = 2'b00;
    localparam logic [1:0] SB_IMM  = 2'b01;
    localparam logic [1:0] SB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    typedef struct packed {
        alu_op_t op;
        logic    wr;
        logic    arith;
        logic    valid;
    } dp_dec_t;

    // Compare/test ops write no register; ADC/SBC/RSC are invalid.
    function automatic dp_dec_t dp_decode(input logic [3:0] cmd);
        dp_dec_t d;
        d.op    = ALU_ADD;
        d.wr    = 1'b1;
        d.arith = 1'b0;
        d.valid = 1'b1;
        case (cmd)
            4'b0000: d.op = ALU_AND;
            4'b0001: d.op = ALU_EOR;
            4'b0010: begin d.op = ALU_SUB; d.arith = 1'b1; end
            4'b0011: begin d.op = ALU_RSB; d.arith = 1'b1; end
            4'b0100: begin d.op = ALU_ADD; d.arith = 1'b1; end
            4'b1100: d.op = ALU_ORR;
            4'b1101: d.op = ALU_MOV;
            4'b1110: d.op = ALU_BIC;
            4'b1111: d.op = ALU_MVN;
            4'b1000: begin d.op = ALU_AND; d.wr = 1'b0; end
            4'b1001: begin d.op = ALU_EOR; d.wr = 1'b0; end
            4'b1010: begin
                d.op = ALU_SUB; d.wr = 1'b0; d.arith = 1'b1;
            end
            4'b1011: begin
                d.op = ALU_ADD; d.wr = 1'b0; d.arith = 1'b1;
            end
            default: begin d.wr = 1'b0; d.valid = 1'b0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/arm_mc_condcheck.sv
// Combinational ARM condition check.
// Ports: cond (Instr[31:28]), flags {N,Z,C,V}, condex (1 = execute).
module arm_mc_condcheck
    import arm_mc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       condex
);

    logic n, z, c, v, ge;

    assign {n, z, c, v} = flags;
    assign ge = (n == v);

    always_comb begin
        condex = 1'b0;
        case (cond)
            C_EQ: condex = z;
            C_NE: condex = ~z;
            C_CS: condex = c;
            C_CC: condex = ~c;
            C_MI: condex = n;
            C_PL: condex = ~n;
            C_VS: condex = v;
            C_VC: condex = ~v;
            C_HI: condex = c & ~z;
            C_LS: condex = ~(c & ~z);
            C_GE: condex = ge;
            C_LT: condex = ~ge;
            C_GT: condex = ~z & ge;
            C_LE: condex = ~(~z & ge);
            C_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM controller: FSM, output decode, NZCV register.
// In: clk, reset (async, low), Instr, ALUFlags, ByteOff, mem_ready.
// Out: datapath enables/selects, ALUControl, be, Flags.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit BYTE_EN       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic [1:0]  ByteOff,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        ShifterSrc,
    output logic [3:0]  ALUControl,
    output logic [3:0]  be,
    output logic [3:0]  Flags
);

    state_t     state, nxt;
    logic [3:0] flags_q;
    logic       condex;
    logic       rdy;
    logic [1:0] op;
    logic       imm;
    logic [3:0] be_mem;
    dp_dec_t    dec;
    logic       unused;

    assign op     = Instr[27:26];
    assign imm    = Instr[25];
    assign dec    = dp_decode(Instr[24:21]);
    assign rdy    = mem_ready | ~MEM_HANDSHAKE;
    assign be_mem = (BYTE_EN && Instr[22]) ? 4'b0001 << ByteOff
                                           : 4'b1111;
    assign unused = ^Instr[19:0];
    assign Flags  = flags_q;

    arm_mc_condcheck u_cond (
        .cond   (Instr[31:28]),
        .flags  (flags_q),
        .condex (condex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_FETCH;
            flags_q <= 4'b0000;
        end else begin
            state <= nxt;
            if (state == S_ALUWB && dec.valid && Instr[20]) begin
                flags_q[3:2] <= ALUFlags[3:2];
                // Logical ops leave C and V untouched.
                if (dec.arith)
                    flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        nxt        = state;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RS_ALUOUT;
        ALUSrcA    = SA_RD1;
        ALUSrcB    = SB_RD2;
        ShifterSrc = 1'b0;
        ALUControl = ALU_ADD;
        be         = 4'b0000;
        ImmSrc     = Instr[27:26];
        RegSrc     = {op == OP_MEM && !Instr[20], op == OP_BR};

        unique case (state)
            S_FETCH: begin
                ALUSrcA    = SA_PC;
                ALUSrcB    = SB_FOUR;
                ResultSrc  = RS_ALURES;
                IRWrite    = rdy;
                PCWrite    = rdy;
                be         = 4'b1111;
                if (rdy) nxt = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    !condex || op == OP_NOP:
                        nxt = S_FETCH;
                    condex && op == OP_MEM:
                        nxt = S_MEMADR;
                    condex && op == OP_DP && imm:
                        nxt = S_EXECI;
                    condex && op == OP_DP && !imm:
                        nxt = S_EXECR;
                    condex && op == OP_BR:
                        nxt = S_BRANCH;
                    default:
                        nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = SB_IMM;
                ALUControl = Instr[23] ? ALU_ADD : ALU_SUB;
                nxt        = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                be     = be_mem;
                if (rdy) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RS_DATA;
                RegWrite  = 1'b1;
                nxt       = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                be       = be_mem;
                if (rdy) nxt = S_FETCH;
            end
            S_EXECR: begin
                ShifterSrc = 1'b1;
                ALUControl = dec.op;
                nxt        = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = SB_IMM;
                ALUControl = dec.op;
                nxt        = S_ALUWB;
            end
            S_ALUWB: begin
                // ALU keeps computing so ALUFlags are valid here.
                ALUSrcB    = imm ? SB_IMM : SB_RD2;
                ShifterSrc = ~imm;
                ALUControl = dec.op;
                RegWrite   = dec.wr;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SA_PC;
                ALUSrcB   = SB_IMM;
                ResultSrc = RS_ALURES;
                PCWrite   = 1'b1;
                RegWrite  = Instr[24];
                nxt       = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase

        if (!reset) begin
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ShifterSrc = 1'b0;
            ALUControl = 4'b0000;
            be         = 4'b0000;
            ImmSrc     = 2'b00;
            RegSrc     = 2'b00;
        end
    end

endmodule
